// File: rtl/l1_i_pkg.sv
// Shared types, default geometry and tree-PLRU helpers for the N-way L1 instruction cache controller.
package l1_i_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MISS   = 2'd1,
    ST_REFILL = 2'd2
  } state_t;

  localparam int TNUM_DEF = 21;
  localparam int INUM_DEF = 5;
  localparam int WAYS_DEF = 4;

  // Tree bits are stored heap-ordered (node n has children 2n+1, 2n+2); a 0 bit sends the victim left.
  function automatic logic [2:0] plru_victim(input logic [6:0] bits, input int levels);
    logic [2:0] w;
    logic [2:0] node;
    w    = '0;
    node = '0;
    for (int l = 0; l < 3; l++) begin
      if (l < levels) begin
        w    = {w[1:0], bits[node]};
        node = {node[1:0], 1'b0} + 3'd1 + {2'b00, bits[node]};
      end
    end
    return w;
  endfunction

  function automatic logic [6:0] plru_update(input logic [6:0] bits, input logic [2:0] way,
                                             input int levels);
    logic [6:0] nb;
    logic [2:0] node;
    logic [2:0] wsh;
    logic       dir;
    nb   = bits;
    node = '0;
    wsh  = way << (3 - levels);
    for (int l = 0; l < 3; l++) begin
      if (l < levels) begin
        dir      = wsh[2];
        nb[node] = ~dir;
        node     = {node[1:0], 1'b0} + 3'd1 + {2'b00, dir};
        wsh      = wsh << 1;
      end
    end
    return nb;
  endfunction

endpackage

// File: rtl/l1_i_plru.sv
// One set's replacement logic: lowest invalid way first, otherwise the tree-PLRU victim,
// plus the tree state after touching access_way.
module l1_i_plru
  import l1_i_pkg::*;
#(
  parameter int WAYS  = WAYS_DEF,
  parameter int WBITS = $clog2(WAYS)
) (
  input  logic [WAYS-2:0]  plru_bits,
  input  logic [WAYS-1:0]  valid,
  input  logic [WBITS-1:0] access_way,
  output logic [WBITS-1:0] victim,
  output logic [WAYS-2:0]  next_bits
);

  logic [6:0] bits_ext;
  logic [2:0] acc_ext;
  logic [2:0] tree_v;
  logic [6:0] upd;
  logic       unused_hi;

  always_comb begin
    bits_ext = '0;
    bits_ext[WAYS-2:0] = plru_bits;
    acc_ext = '0;
    acc_ext[WBITS-1:0] = access_way;
    tree_v    = plru_victim(bits_ext, WBITS);
    upd       = plru_update(bits_ext, acc_ext, WBITS);
    next_bits = upd[WAYS-2:0];
    victim    = tree_v[WBITS-1:0];
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!valid[i]) victim = WBITS'(i);
    end
  end

  assign unused_hi = ^{tree_v, upd};

endmodule

// File: rtl/l1_i_nway_controller.sv
// N-way set-associative L1 instruction cache tag/control with tree-PLRU replacement.
// Optional hit/miss performance counters are built when L1I_PERF_CNT_EN is defined.
module l1_i_nway_controller
  import l1_i_pkg::*;
#(
  parameter int TNUM  = TNUM_DEF,
  parameter int INUM  = INUM_DEF,
  parameter int WAYS  = WAYS_DEF,
  parameter int WBITS = $clog2(WAYS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [TNUM-1:0]  tag_C_L1,
  input  logic [INUM-1:0]  index_C_L1,
  input  logic             read_C_L1,
  input  logic             flush,
  input  logic             ready_L2_L1,
  output logic             stall,
  output logic             hit,
  output logic             refill,
  output logic [WBITS-1:0] way,
  output logic             read_L1_L2,
  output logic [INUM-1:0]  index_L1_L2,
  output logic [TNUM-1:0]  tag_L1_L2
`ifdef L1I_PERF_CNT_EN
  ,
  output logic [31:0]      hit_cnt,
  output logic [31:0]      miss_cnt
`endif
);

  localparam int SETS = 1 << INUM;

  state_t state_q, state_d;

  logic [TNUM-1:0]  tag_mem [SETS][WAYS];
  logic [WAYS-1:0]  valid_q [SETS];
  logic [WAYS-2:0]  plru_q  [SETS];

  logic [TNUM-1:0]  miss_tag_q;
  logic [INUM-1:0]  miss_idx_q;
  logic [WBITS-1:0] victim_q;

  logic [INUM-1:0]  sel_idx;
  logic             hit_any;
  logic [WBITS-1:0] hit_way;
  logic [WBITS-1:0] acc_way;
  logic [WBITS-1:0] victim_c;
  logic [WAYS-2:0]  plru_next;
  logic             plru_we;
  logic             latch_miss;
  logic             write_fill;

  // Outside IDLE the only set of interest is the one with the outstanding miss.
  always_comb begin
    sel_idx = (state_q == ST_IDLE) ? index_C_L1 : miss_idx_q;
    hit_any = 1'b0;
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[sel_idx][w] && (tag_mem[sel_idx][w] == tag_C_L1)) begin
        hit_any = 1'b1;
        hit_way = WBITS'(w);
      end
    end
  end

  l1_i_plru #(.WAYS(WAYS), .WBITS(WBITS)) u_plru (
    .plru_bits  (plru_q[sel_idx]),
    .valid      (valid_q[sel_idx]),
    .access_way (acc_way),
    .victim     (victim_c),
    .next_bits  (plru_next)
  );

  always_comb begin
    state_d    = state_q;
    stall      = 1'b0;
    hit        = 1'b0;
    refill     = 1'b0;
    way        = '0;
    read_L1_L2 = 1'b0;
    plru_we    = 1'b0;
    acc_way    = hit_way;
    latch_miss = 1'b0;
    write_fill = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (read_C_L1) begin
          if (hit_any) begin
            hit     = 1'b1;
            way     = hit_way;
            plru_we = 1'b1;
          end else begin
            stall      = 1'b1;
            latch_miss = 1'b1;
            state_d    = ST_MISS;
          end
        end
      end
      ST_MISS: begin
        stall      = 1'b1;
        read_L1_L2 = 1'b1;
        if (ready_L2_L1) state_d = ST_REFILL;
      end
      ST_REFILL: begin
        stall      = 1'b1;
        refill     = 1'b1;
        way        = victim_q;
        acc_way    = victim_q;
        plru_we    = 1'b1;
        write_fill = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Flush wins over any lookup or fill in flight.
    if (flush) begin
      state_d    = ST_IDLE;
      stall      = 1'b1;
      hit        = 1'b0;
      refill     = 1'b0;
      way        = '0;
      plru_we    = 1'b0;
      latch_miss = 1'b0;
      write_fill = 1'b0;
    end
    if (rst) begin
      state_d    = ST_IDLE;
      stall      = 1'b0;
      hit        = 1'b0;
      refill     = 1'b0;
      way        = '0;
      read_L1_L2 = 1'b0;
      plru_we    = 1'b0;
      latch_miss = 1'b0;
      write_fill = 1'b0;
    end
  end

  assign index_L1_L2 = rst ? '0 : miss_idx_q;
  assign tag_L1_L2   = rst ? '0 : miss_tag_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      miss_tag_q <= '0;
      miss_idx_q <= '0;
      victim_q   <= '0;
    end else begin
      state_q <= state_d;
      if (latch_miss) begin
        miss_tag_q <= tag_C_L1;
        miss_idx_q <= index_C_L1;
      end
      // The set is frozen while the miss is outstanding, so the last MISS-cycle choice is final.
      if (state_q == ST_MISS) victim_q <= victim_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      if (write_fill) valid_q[miss_idx_q][victim_q] <= 1'b1;
      if (plru_we) plru_q[sel_idx] <= plru_next;
    end
  end

  always_ff @(posedge clk) begin
    if (write_fill) tag_mem[miss_idx_q][victim_q] <= miss_tag_q;
  end

`ifdef L1I_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit && (hit_cnt != '1)) hit_cnt <= hit_cnt + 32'd1;
      if (latch_miss && (miss_cnt != '1)) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`else
  // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_l1_i_nway_controller.sv
// Randomized scoreboard bench for l1_i_nway_controller against a set/way/PLRU-tree model.
module tb_l1_i_nway_controller;

  localparam int TNUM  = 21;
  localparam int INUM  = 5;
  localparam int WAYS  = 4;
  localparam int WBITS = 2;
  localparam int SETS  = 32;

  localparam int EV_HIT  = 1;
  localparam int EV_REQ  = 2;
  localparam int EV_FILL = 3;

  logic             clk = 1'b0;
  logic             rst, read, flush, ready;
  logic [TNUM-1:0]  tag;
  logic [INUM-1:0]  idx;
  logic             stall, hit, refill, read_L1_L2;
  logic [WBITS-1:0] way;
  logic [INUM-1:0]  index_L1_L2;
  logic [TNUM-1:0]  tag_L1_L2;
`ifdef L1I_PERF_CNT_EN
  logic [31:0]      hit_cnt, miss_cnt;
`endif

  always #5 clk = ~clk;

  l1_i_nway_controller #(.TNUM(TNUM), .INUM(INUM), .WAYS(WAYS)) dut (
    .clk         (clk),
    .rst         (rst),
    .tag_C_L1    (tag),
    .index_C_L1  (idx),
    .read_C_L1   (read),
    .flush       (flush),
    .ready_L2_L1 (ready),
    .stall       (stall),
    .hit         (hit),
    .refill      (refill),
    .way         (way),
    .read_L1_L2  (read_L1_L2),
    .index_L1_L2 (index_L1_L2),
    .tag_L1_L2   (tag_L1_L2)
`ifdef L1I_PERF_CNT_EN
    ,
    .hit_cnt     (hit_cnt),
    .miss_cnt    (miss_cnt)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int kind;
    int way;
    int tag;
    int idx;
  } ev_t;
  ev_t q[$];

  // Reference: tags and valids per set/way; per tree node, which half was touched most recently.
  int m_tag  [SETS][WAYS];
  bit m_val  [SETS][WAYS];
  bit m_last [SETS][WAYS];
  int m_hits = 0;
  int m_misses = 0;
  int last_fill_way = -1;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void m_clear();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        m_val[s][w]  = 1'b0;
        m_last[s][w] = 1'b1;
      end
    m_hits   = 0;
    m_misses = 0;
  endfunction

  function automatic int m_lookup(input int t, input int s);
    for (int w = 0; w < WAYS; w++)
      if (m_val[s][w] && m_tag[s][w] == t) return w;
    return -1;
  endfunction

  function automatic void m_touch(input int s, input int w);
    int lo, size, node, half;
    lo = 0; size = WAYS; node = 1;
    while (size > 1) begin
      half = size / 2;
      if (w >= lo + half) begin
        m_last[s][node] = 1'b1;
        lo   = lo + half;
        node = 2 * node + 1;
      end else begin
        m_last[s][node] = 1'b0;
        node = 2 * node;
      end
      size = half;
    end
  endfunction

  function automatic int m_victim(input int s);
    int lo, size, node, half;
    for (int w = 0; w < WAYS; w++)
      if (!m_val[s][w]) return w;
    lo = 0; size = WAYS; node = 1;
    while (size > 1) begin
      half = size / 2;
      if (m_last[s][node]) node = 2 * node;
      else begin
        lo   = lo + half;
        node = 2 * node + 1;
      end
      size = half;
    end
    return lo;
  endfunction

  task automatic pop_chk(input int kind, input int w, input int t, input int i);
    ev_t e;
    if (q.size() == 0) begin
      chk("event_kind_unexpected", kind, 0);
      return;
    end
    e = q.pop_front();
    chk("event_kind", kind, e.kind);
    if (kind == e.kind) begin
      if (kind == EV_REQ) begin
        chk("l2_tag", t, e.tag);
        chk("l2_index", i, e.idx);
      end else begin
        chk(kind == EV_HIT ? "hit_way" : "refill_way", w, e.way);
      end
    end
  endtask

  bit prev_rd = 1'b0;
  always @(negedge clk) begin
    if (rst) prev_rd = 1'b0;
    else begin
      if (hit) begin
        pop_chk(EV_HIT, int'(way), 0, 0);
        chk("hit_stall", int'(stall), 0);
      end
      if (refill) begin
        last_fill_way = int'(way);
        pop_chk(EV_FILL, int'(way), 0, 0);
        chk("refill_stall", int'(stall), 1);
        chk("refill_rd_l2", int'(read_L1_L2), 0);
      end
      if (read_L1_L2 && !prev_rd) begin
        pop_chk(EV_REQ, 0, int'(tag_L1_L2), int'(index_L1_L2));
        chk("miss_stall", int'(stall), 1);
      end
      prev_rd = read_L1_L2;
    end
  end

  // mode 0: normal refill, 1: flush while in MISS, 2: reset during REFILL
  task automatic do_read(input int t, input int s, input int lat, input int mode,
                         output bit was_miss);
    int w, v;
    @(posedge clk); #1;
    read = 1'b1; tag = TNUM'(t); idx = INUM'(s);
    w = m_lookup(t, s);
    if (w >= 0) begin
      q.push_back('{EV_HIT, w, 0, 0});
      m_touch(s, w);
      m_hits++;
    end else begin
      q.push_back('{EV_REQ, 0, t, s});
      m_misses++;
    end
    @(negedge clk);
    was_miss = stall;
    chk("issue_stall", int'(stall), (w < 0) ? 1 : 0);
    if (w >= 0) begin
      @(posedge clk); #1 read = 1'b0;
      return;
    end
    @(posedge clk);
    repeat (lat - 1) @(posedge clk);
    #1;
    if (mode == 1) begin
      flush = 1'b1; read = 1'b0;
      m_clear();
      @(negedge clk);
      chk("flush_stall", int'(stall), 1);
      @(posedge clk); #1 flush = 1'b0;
      @(negedge clk);
      chk("flush_drop_rd_l2", int'(read_L1_L2), 0);
      chk("flush_no_refill", int'(refill), 0);
      return;
    end
    ready = 1'b1;
    v = m_victim(s);
    if (mode == 2) begin
      @(posedge clk); #1;
      ready = 1'b0; rst = 1'b1; read = 1'b0;
      m_clear();
      @(negedge clk);
      chk("rst_refill", int'(refill), 0);
      chk("rst_stall", int'(stall), 0);
      chk("rst_tag_l2", int'(tag_L1_L2), 0);
      @(posedge clk); #1 rst = 1'b0;
      return;
    end
    q.push_back('{EV_FILL, v, 0, 0});
    m_tag[s][v] = t;
    m_val[s][v] = 1'b1;
    m_touch(s, v);
    q.push_back('{EV_HIT, v, 0, 0});
    m_touch(s, v);
    m_hits++;
    @(posedge clk); #1 ready = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 read = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit wm;
    int r;
    rst = 1'b1; read = 1'b1; flush = 1'b0; ready = 1'b0;
    tag = TNUM'(1); idx = INUM'(3);
    m_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", int'(stall), 0);
    chk("rst_hit", int'(hit), 0);
    chk("rst_refill", int'(refill), 0);
    chk("rst_way", int'(way), 0);
    chk("rst_rd_l2", int'(read_L1_L2), 0);
    chk("rst_idx_l2", int'(index_L1_L2), 0);
    @(posedge clk); #1 rst = 1'b0; read = 1'b0;
    @(negedge clk);
    chk("idle_stall", int'(stall), 0);
    chk("idle_hit", int'(hit), 0);

    do_read(1, 3, 4, 0, wm);
    chk("cold_miss", int'(wm), 1);
    chk("cold_fill_way", last_fill_way, 0);
    do_read(2, 3, 2, 0, wm);
    chk("fill2_way", last_fill_way, 1);
    do_read(3, 3, 3, 0, wm);
    chk("fill3_way", last_fill_way, 2);
    do_read(4, 3, 1, 0, wm);
    chk("fill4_way", last_fill_way, 3);
    do_read(1, 3, 1, 0, wm);
    chk("reread1_hit", int'(wm), 0);
    do_read(5, 3, 2, 0, wm);
    chk("plru_victim_way", last_fill_way, 2);
    do_read(3, 3, 2, 0, wm);
    chk("evicted3_miss", int'(wm), 1);

    do_read(6, 3, 2, 1, wm);
    do_read(1, 3, 3, 0, wm);
    chk("after_flush_miss", int'(wm), 1);

    do_read(2, 3, 3, 2, wm);
    do_read(2, 3, 2, 0, wm);
    chk("after_rst_refill_miss", int'(wm), 1);

    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 99);
      do_read($urandom_range(1, 7), $urandom_range(0, 3), $urandom_range(1, 6),
              (r < 4) ? 1 : ((r < 6) ? 2 : 0), wm);
      r = $urandom_range(0, 99);
      if (r < 6) begin
        @(posedge clk); #1 flush = 1'b1; ready = 1'($urandom_range(0, 1));
        m_clear();
        @(negedge clk);
        chk("idle_flush_stall", int'(stall), 1);
        @(posedge clk); #1 flush = 1'b0; ready = 1'b0;
      end else if (r < 20) begin
        @(posedge clk); #1 ready = 1'b1;
        @(negedge clk);
        chk("idle_ready_ignored", int'(read_L1_L2), 0);
        @(posedge clk); #1 ready = 1'b0;
      end
    end

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("queue_empty", q.size(), 0);
`ifdef L1I_PERF_CNT_EN
    chk("hit_cnt", int'(hit_cnt), m_hits);
    chk("miss_cnt", int'(miss_cnt), m_misses);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
